// File: rtl/lsu_bus_bridge.sv
// Bridge from the load/store controller to a req/gnt/rvalid data bus.
// It stalls the core for one access and returns the aligned, extended load value.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  input  logic [2:0]  req_load_ctrl,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_mask;
  logic [2:0]    r_ctrl;
  logic [31:0]   r_load_data;
  logic          r_err;

  logic [1:0]    w_state_nxt;
  logic          w_capture;
  logic          w_abort;
  logic          w_timeout;
  logic          w_in_req;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_aligned;

  assign w_in_req  = (r_state == S_REQ);
  // Last permitted REQ/RESP cycle; a completion in this same cycle still wins.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = (req_we && (req_mask == 4'b0000)) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt && (r_we || bus_rvalid)) begin
          w_state_nxt = S_DONE;
          w_capture   = !r_we;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end else if (bus_gnt) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus_rvalid) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_ctrl)
      3'b000:  w_aligned = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_aligned = {{16{w_half[15]}}, w_half};
      3'b010:  w_aligned = bus_rdata;
      3'b011:  w_aligned = {24'd0, w_byte};
      default: w_aligned = {16'd0, w_half};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_mask      <= 4'd0;
      r_ctrl      <= 3'd0;
      r_load_data <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mask  <= req_mask;
        r_ctrl  <= req_load_ctrl;
        r_cnt   <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Stores and aborts retire with a zero result; only a capture loads data.
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        r_load_data <= w_capture ? w_aligned : 32'd0;
        r_err       <= w_abort;
      end
    end
  end

  assign stall     = (r_state == S_IDLE) ? req_valid : (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_err;
  assign load_data = r_load_data;
  assign bus_req   = w_in_req;
  assign bus_we    = w_in_req && r_we;
  assign bus_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus_wdata = w_in_req ? r_wdata : 32'd0;
  assign bus_be    = w_in_req ? (r_we ? r_mask : 4'b1111) : 4'b0000;
  assign dbg_state = r_state;

endmodule
